// File: rtl/serial_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// serial_deserializer_pkg
//   Shared types and constants for the serial deserializer slice.
//   - state_t         : framing FSM states (IDLE, SHIFT)
//   - DEFAULT_PATTERN : reference word used by the match flag (16'h539F)
// -----------------------------------------------------------------------------
package serial_deserializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [15:0] DEFAULT_PATTERN = 16'h539F;

endpackage : serial_deserializer_pkg

// File: rtl/serial_deserializer_if.sv
// -----------------------------------------------------------------------------
// serial_deserializer_if
//   Bundles the serial input side and the parallel result side of the
//   deserializer.
//   Serial side  : start, din, din_en          (driven by the source)
//   Result side  : data, data_valid, match, busy, frame_err, match_cnt
//   Modports:
//     master - serial source / checker (drives serial side, reads results)
//     slave  - the deserializer itself
// -----------------------------------------------------------------------------
interface serial_deserializer_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
);

   logic             start;
   logic             din;
   logic             din_en;
   logic [WIDTH-1:0] data;
   logic             data_valid;
   logic             match;
   logic             busy;
   logic             frame_err;
   logic [CNT_W-1:0] match_cnt;

   modport master (
      output start, din, din_en,
      input  data, data_valid, match, busy, frame_err, match_cnt
   );

   modport slave (
      input  start, din, din_en,
      output data, data_valid, match, busy, frame_err, match_cnt
   );

endinterface : serial_deserializer_if

// File: rtl/serial_deserializer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at its all-ones value instead of wrapping.
//   Ports:
//     clk   - rising-edge clock
//     rst   - asynchronous active-high reset, clears count
//     inc   - add one on this edge (ignored once saturated)
//     count - current value, CNT_W bits
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule : sat_counter

// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
//   Reassembles an LSB-first serial stream into WIDTH-bit words. A frame is
//   opened by start (qualified by din_en), collects WIDTH qualified bits, then
//   publishes the word with a one-cycle data_valid pulse and a registered
//   match flag. Matching frames are counted in a saturating counter. A start
//   inside a frame drops the partial word, pulses frame_err and restarts.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - serial_deserializer_if.slave (start/din/din_en in;
//            data/data_valid/match/busy/frame_err/match_cnt out)
// -----------------------------------------------------------------------------
module serial_deserializer
   import serial_deserializer_pkg::*;
#(
   parameter int               WIDTH   = 16,
   parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEFAULT_PATTERN),
   parameter int               CNT_W   = 8
) (
   input logic                  clk,
   input logic                  rst,
   serial_deserializer_if.slave bus
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   state_t           state, state_next;
   logic [WIDTH-1:0] shift_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] data_q;
   logic             match_q;
   logic             valid_q;
   logic             err_q;

   // Control decoded from the current state and qualified inputs.
   logic             load_first;   // capture din as bit 0 of a new frame
   logic             shift_bit;    // store din at position cnt_q, frame continues
   logic             frame_done;   // store final bit and publish the word
   logic             abort;        // start arrived while a frame was open
   logic [WIDTH-1:0] word_c;       // shift_q with the incoming bit merged in

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and control decode
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_next = state;
      load_first = 1'b0;
      shift_bit  = 1'b0;
      frame_done = 1'b0;
      abort      = 1'b0;

      word_c         = shift_q;
      word_c[cnt_q]  = bus.din;

      unique case (state)
         IDLE: begin
            if (bus.din_en && bus.start) begin
               load_first = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.din_en) begin
               if (bus.start) begin
                  // Restart in place: the new frame begins on this very bit.
                  load_first = 1'b1;
                  abort      = 1'b1;
               end else if (cnt_q == LAST_IDX) begin
                  frame_done = 1'b1;
                  state_next = IDLE;
               end else begin
                  shift_bit = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: shift register, bit counter, published word and pulses
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         match_q <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here, so every register samples the
         // pre-edge values regardless of statement order.
         valid_q <= frame_done;
         err_q   <= abort;

         if (load_first) begin
            // Upper bits cleared so a restarted frame never carries stale bits.
            shift_q <= WIDTH'(bus.din);
            cnt_q   <= CW'(1);
         end else if (shift_bit) begin
            shift_q <= word_c;
            cnt_q   <= cnt_q + CW'(1);
         end

         if (frame_done) begin
            data_q  <= word_c;
            match_q <= (word_c == PATTERN);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Matched-frame counter
   // ---------------------------------------------------------------------------
   sat_counter #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (frame_done && (word_c == PATTERN)),
      .count (bus.match_cnt)
   );

   assign bus.data       = data_q;
   assign bus.match      = match_q;
   assign bus.data_valid = valid_q;
   assign bus.frame_err  = err_q;
   assign bus.busy       = (state == SHIFT);

endmodule : serial_deserializer

// File: tb/tb_serial_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_deserializer
//   Drives two deserializers (CNT_W=8 and CNT_W=2) with the same serial
//   stream and compares every cycle against a frame-level reference model
//   built on a queue of received bits.
// -----------------------------------------------------------------------------
module tb_serial_deserializer;

   localparam int          WIDTH   = 16;
   localparam logic [15:0] PATTERN = 16'h539F;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_deserializer_if #(.WIDTH(WIDTH), .CNT_W(8)) bus ();
   serial_deserializer_if #(.WIDTH(WIDTH), .CNT_W(2)) bus_sat ();

   assign bus_sat.start  = bus.start;
   assign bus_sat.din    = bus.din;
   assign bus_sat.din_en = bus.din_en;

   serial_deserializer #(.WIDTH(WIDTH), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   serial_deserializer #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus_sat)
   );

   // ---------------------------------------------------------------------------
   // Counters and reference model state
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   bit          in_frame;
   bit          bits[$];
   logic [15:0] exp_data;
   logic        exp_match, exp_valid, exp_err;
   int          exp_cnt, exp_cnt_sat;

   int cyc       = 0;
   int valid_cyc = -1;
   int valid_cnt = 0;
   int err_cnt   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      in_frame    = 1'b0;
      bits.delete();
      exp_data    = '0;
      exp_match   = 1'b0;
      exp_valid   = 1'b0;
      exp_err     = 1'b0;
      exp_cnt     = 0;
      exp_cnt_sat = 0;
   endtask

   // One clock edge of the frame rules: collect bits in a queue, publish
   // when the queue holds a whole word.
   task automatic model_step(input logic s, input logic d, input logic e);
      logic [15:0] w;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (e) begin
         if (s) begin
            if (in_frame) exp_err = 1'b1;
            bits.delete();
            bits.push_back(d);
            in_frame = 1'b1;
         end else if (in_frame) begin
            bits.push_back(d);
         end
         if (in_frame && bits.size() == WIDTH) begin
            w = '0;
            for (int i = 0; i < WIDTH; i++) w[i] = bits[i];
            exp_data  = w;
            exp_match = (w == PATTERN);
            exp_valid = 1'b1;
            if (exp_match) begin
               if (exp_cnt < 255) exp_cnt++;
               if (exp_cnt_sat < 3) exp_cnt_sat++;
            end
            in_frame = 1'b0;
            bits.delete();
         end
      end
   endtask

   task automatic compare_all();
      check("data",      32'(bus.data),           32'(exp_data));
      check("match",     32'(bus.match),          32'(exp_match));
      check("valid",     32'(bus.data_valid),     32'(exp_valid));
      check("frame_err", 32'(bus.frame_err),      32'(exp_err));
      check("busy",      32'(bus.busy),           32'(in_frame));
      check("match_cnt", 32'(bus.match_cnt),      32'(exp_cnt));
      check("sat_valid", 32'(bus_sat.data_valid), 32'(exp_valid));
      check("sat_cnt",   32'(bus_sat.match_cnt),  32'(exp_cnt_sat));
   endtask

   // Called at a falling edge: drive, let the rising edge happen, check.
   task automatic cycle(input logic s, input logic d, input logic e);
      bus.start  = s;
      bus.din    = d;
      bus.din_en = e;
      @(posedge clk);
      model_step(s, d, e);
      cyc++;
      @(negedge clk);
      compare_all();
      if (bus.data_valid) begin
         valid_cyc = cyc;
         valid_cnt++;
      end
      if (bus.frame_err) err_cnt++;
   endtask

   // Sends a whole word LSB first, optionally inserting din_en=0 cycles after
   // bit gap_at. Returns start-to-valid latency in cycles (-1 if none).
   task automatic send_word(input logic [15:0] w, input int gap_at, input int gap_len,
                            output int lat);
      int s0;
      valid_cyc = -1;
      s0 = cyc + 1;
      for (int i = 0; i < WIDTH; i++) begin
         cycle(i == 0, w[i], 1'b1);
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         end
      end
      lat = (valid_cyc < 0) ? -1 : valid_cyc - s0 + 1;
   endtask

   task automatic outputs_zero(input string tag);
      check({tag, "_data"},  32'(bus.data),          32'd0);
      check({tag, "_valid"}, 32'(bus.data_valid),    32'd0);
      check({tag, "_match"}, 32'(bus.match),         32'd0);
      check({tag, "_busy"},  32'(bus.busy),          32'd0);
      check({tag, "_err"},   32'(bus.frame_err),     32'd0);
      check({tag, "_cnt"},   32'(bus.match_cnt),     32'd0);
      check({tag, "_scnt"},  32'(bus_sat.match_cnt), 32'd0);
   endtask

   // Asynchronous reset pulse starting between clock edges.
   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1 outputs_zero(tag);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int lat;
      int v0, e0;
      logic [15:0] w;
      logic [15:0] abort_word;
      int sat_exp[5] = '{1, 2, 3, 3, 3};

      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.din    = 1'b0;
      bus.din_en = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      outputs_zero("reset");
      rst = 1'b0;

      // Ignored inputs in IDLE: start without din_en, din_en without start.
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b1);

      // Default pattern, continuous din_en.
      send_word(PATTERN, -1, 0, lat);
      check("pat_latency", 32'(lat), 32'd16);
      check("pat_cnt",     32'(bus.match_cnt), 32'd1);
      cycle(1'b0, 1'b0, 1'b0);

      // Non-matching frame.
      send_word(16'hFFFF, -1, 0, lat);
      check("ffff_data", 32'(bus.data), 32'hFFFF);
      check("ffff_cnt",  32'(bus.match_cnt), 32'd1);
      cycle(1'b0, 1'b0, 1'b0);

      // Three-cycle qualifier gap after bit 5.
      e0 = err_cnt;
      send_word(PATTERN, 5, 3, lat);
      check("gap_latency", 32'(lat), 32'd19);
      check("gap_no_err",  32'(err_cnt - e0), 32'd0);

      // Abort at bit 7, then a full new frame.
      e0 = err_cnt;
      v0 = valid_cnt;
      abort_word = 16'($urandom);
      for (int i = 0; i < 7; i++) cycle(i == 0, abort_word[i], 1'b1);
      w = 16'hA5C3;
      send_word(w, -1, 0, lat);
      check("abort_err_cnt", 32'(err_cnt - e0),   32'd1);
      check("abort_valids",  32'(valid_cnt - v0), 32'd1);
      check("abort_latency", 32'(lat),            32'd16);
      check("abort_data",    32'(bus.data),       32'(w));

      // Start with din_en=0 inside a frame is ignored.
      for (int i = 0; i < 4; i++) cycle(i == 0, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 4; i < WIDTH; i++) cycle(1'b0, 1'(i & 1), 1'b1);

      // Reset during bit 10, then a clean frame.
      for (int i = 0; i < 10; i++) cycle(i == 0, PATTERN[i], 1'b1);
      bus.start  = 1'b0;
      bus.din    = PATTERN[10];
      bus.din_en = 1'b1;
      v0 = valid_cnt;
      async_reset("midreset");
      check("midreset_no_valid", 32'(valid_cnt - v0), 32'd0);
      send_word(PATTERN, -1, 0, lat);
      check("post_reset_lat",   32'(lat),           32'd16);
      check("post_reset_match", 32'(bus.match),     32'd1);
      check("post_reset_cnt",   32'(bus.match_cnt), 32'd1);

      // Back-to-back matching frames; saturation on the CNT_W=2 instance.
      async_reset("pre_sat");
      v0 = valid_cnt;
      for (int k = 0; k < 5; k++) begin
         send_word(PATTERN, -1, 0, lat);
         check("b2b_latency", 32'(lat), 32'd16);
         check("sat_seq",     32'(bus_sat.match_cnt), 32'(sat_exp[k]));
      end
      check("b2b_valids", 32'(valid_cnt - v0), 32'd5);
      check("b2b_cnt8",   32'(bus.match_cnt),  32'd5);

      // Randomized frames: mix of pattern / random words, random gaps.
      for (int n = 0; n < 40; n++) begin
         w = ($urandom_range(0, 1) == 1) ? PATTERN : 16'($urandom);
         send_word(w, int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), lat);
         if ($urandom_range(0, 2) == 0) cycle(1'b0, 1'b0, 1'b0);
      end

      // Fully random bit-level traffic, including aborts and ignored starts.
      for (int n = 0; n < 1500; n++) begin
         cycle(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_serial_deserializer

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Receive end of the serial D-bit stream that our flip-flop benches drive: bits arrive one per qualified clock, LSB first, and this block reassembles them into a WIDTH-bit word.
- Frames the stream with a start strobe and publishes each completed word with a one-cycle valid pulse.
- Compares each word against a reference pattern and keeps a saturating count of matching frames.
- Sits between a serial source (FF chain or bench driver) and parallel checking/display logic.

Parameters:
- WIDTH, 16, bits per frame; must be >= 2.
- PATTERN, 16'b0101001110011111 (16'h539F), reference word for the match flag; WIDTH bits.
- CNT_W, 8, width of match_cnt.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  frame start; meaningful only when din_en=1 in the same cycle.
- din  input  1  serial data bit.
- din_en  input  1  bit qualifier; din is sampled only when din_en=1.
- data  output  WIDTH  last completed word; bit i is the i-th received bit.
- data_valid  output  1  one-cycle pulse when data updates.
- match  output  1  (data == PATTERN), registered together with data.
- busy  output  1  high while a frame is in progress (state SHIFT).
- frame_err  output  1  one-cycle pulse when start aborts a partial frame.
- match_cnt  output  CNT_W  saturating count of matched frames.

Behaviour:
- Reset (async, any time): state=IDLE; shift register, bit counter, data, match, match_cnt = 0; data_valid, frame_err, busy = 0. A partial frame is discarded and no data_valid is produced.
- States: IDLE, SHIFT.
- IDLE, start=1 with din_en=1: sample din as bit 0, set counter=1, go to SHIFT. start with din_en=0 is ignored. din_en without start is ignored.
- SHIFT, din_en=1 and start=0: write din into shift[counter] and increment counter. din_en=0: hold state and counter, so gaps of any length are allowed.
- SHIFT, last bit (counter==WIDTH-1 with din_en=1, start=0): on that edge, load data with the full word, register match, and pulse data_valid high for the following cycle. If match, increment match_cnt. Return to IDLE.
- Latency: data_valid is high in the cycle right after the edge that samples the last bit.
- SHIFT, start=1 with din_en=1: abort the partial frame, pulse frame_err for one cycle, and restart with din as bit 0, counter=1, staying in SHIFT.
- SHIFT, start=1 with din_en=0: start is ignored.
- Back-to-back frames: start may be asserted in the data_valid cycle, because the state is already IDLE then. No bubble is required.
- data and match hold their values until the next completed frame.
- match_cnt saturates at 2^CNT_W-1 and never wraps.
- busy = (state==SHIFT).
- Counter width is clog2(WIDTH).

Decomposition:
- Shared package: state enum (IDLE, SHIFT) and the default pattern constant, 16'h539F.
- One sub-module: sat_counter (parameter CNT_W; ports clk, rst, inc, count), used for match_cnt.

Test Plan:
- Default pattern: reset, then start with bit 0, sending 16'h539F LSB first with continuous din_en -> data_valid for exactly one cycle after the 16th edge; data=16'h539F, match=1, match_cnt=1, busy low in that cycle.
- Non-matching frame: send 16'hFFFF -> data=16'hFFFF, match=0, match_cnt unchanged at 1.
- Qualifier gaps: send 16'h539F with din_en=0 for 3 cycles after bit 5 -> data=16'h539F, data_valid 3 cycles later than the gap-free case, no frame_err.
- Abort: start again at bit 7 of a frame -> frame_err pulses once; data_valid appears only after 16 more accepted bits; data holds the new frame's bits.
- Reset mid-frame: assert rst during bit 10 -> all outputs 0 immediately; no data_valid; the next full 16'h539F frame gives data_valid, match=1, match_cnt=1.
- Back-to-back and saturation (CNT_W=2): 5 consecutive matching frames, each start in the prior data_valid cycle -> 5 data_valid pulses; match_cnt reads 1, 2, 3, 3, 3.
